// File: rtl/smartbing_lid_ctrl_if.sv
// rtl/smartbing_lid_ctrl_if.sv - sensor/actuator pin bundle for the lid controller
// Ports (signals):
//   sense_user, lim_open, lim_closed, fill_lo, fill_hi : raw asynchronous sensor pins
//   motor_open, motor_close                            : lid motor drive
//   full_lo, full_hi, alarm                            : indicators
//   state[2:0]                                         : debug view of the FSM state
// Modports: master = board/environment side, slave = controller side.
interface smartbing_lid_ctrl_if;
  logic       sense_user;
  logic       lim_open;
  logic       lim_closed;
  logic       fill_lo;
  logic       fill_hi;
  logic       motor_open;
  logic       motor_close;
  logic       full_lo;
  logic       full_hi;
  logic       alarm;
  logic [2:0] state;

  modport master (
    output sense_user, lim_open, lim_closed, fill_lo, fill_hi,
    input  motor_open, motor_close, full_lo, full_hi, alarm, state
  );

  modport slave (
    input  sense_user, lim_open, lim_closed, fill_lo, fill_hi,
    output motor_open, motor_close, full_lo, full_hi, alarm, state
  );
endinterface

// File: rtl/smartbing_lid_ctrl.sv
// rtl/smartbing_lid_ctrl.sv - SmartBing lid sequencing controller
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   io    : smartbing_lid_ctrl_if.slave (sensor inputs, motor/indicator/state outputs)
// Parameters: DEB_CYC debounce length, HOLD_CYC open dwell, TIMEOUT_CYC motion
// limit, ALARM_CYC full-bin alarm length.
module smartbing_lid_ctrl #(
  parameter int DEB_CYC     = 4,
  parameter int HOLD_CYC    = 1000,
  parameter int TIMEOUT_CYC = 2000,
  parameter int ALARM_CYC   = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  smartbing_lid_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OPENING = 3'd1,
    HOLD    = 3'd2,
    CLOSING = 3'd3,
    DENY    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [7:0]  DEB_Q    = 8'(DEB_CYC);
  localparam logic [15:0] HOLD_Q   = 16'(HOLD_CYC);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] ALARM_Q  = 16'(ALARM_CYC);

  // Two-flop synchronisers; bit 1 is the synchronised value.
  logic [1:0] user_sync;
  logic [1:0] lopen_sync;
  logic [1:0] lclosed_sync;
  logic [1:0] flo_sync;
  logic [1:0] fhi_sync;

  logic s_user;
  logic s_lopen;
  logic s_lclosed;

  logic [7:0]  deb_cnt;
  logic        req;

  state_t      st;
  state_t      nxt_st;
  logic [15:0] tmo_cnt;
  logic [15:0] hold_cnt;
  logic [15:0] alarm_cnt;
  logic [15:0] nxt_tmo;
  logic [15:0] nxt_hold;
  logic [15:0] nxt_alarm;

  logic motor_open_q;
  logic motor_close_q;
  logic alarm_q;
  logic full_lo_q;
  logic full_hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      user_sync    <= 2'b00;
      lopen_sync   <= 2'b00;
      lclosed_sync <= 2'b00;
      flo_sync     <= 2'b00;
      fhi_sync     <= 2'b00;
    end else begin
      user_sync    <= {user_sync[0],    io.sense_user};
      lopen_sync   <= {lopen_sync[0],   io.lim_open};
      lclosed_sync <= {lclosed_sync[0], io.lim_closed};
      flo_sync     <= {flo_sync[0],     io.fill_lo};
      fhi_sync     <= {fhi_sync[0],     io.fill_hi};
    end
  end

  assign s_user    = user_sync[1];
  assign s_lopen   = lopen_sync[1];
  assign s_lclosed = lclosed_sync[1];

  // Debounce: saturating run-length of synchronised highs. Holding the
  // sensor keeps the counter parked at DEB_CYC, so req stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= 8'd0;
    end else if (!s_user) begin
      deb_cnt <= 8'd0;
    end else if (deb_cnt != DEB_Q) begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  end

  assign req = (deb_cnt == DEB_Q);

  // Next-state and counter update. Conflicting limit switches beat
  // everything, then timeout, then limit switches, then req.
  always_comb begin
    nxt_st    = st;
    nxt_tmo   = tmo_cnt;
    nxt_hold  = hold_cnt;
    nxt_alarm = alarm_cnt;
    if (st != FAULT && s_lopen && s_lclosed) begin
      nxt_st = FAULT;
    end else begin
      case (st)
        IDLE: begin
          if (req && full_hi_q) begin
            nxt_st    = DENY;
            nxt_alarm = ALARM_Q;
          end else if (req) begin
            nxt_st  = OPENING;
            nxt_tmo = 16'd0;
          end
        end
        OPENING: begin
          if (tmo_cnt == TMO_LAST) begin
            nxt_st = FAULT;
          end else if (s_lopen) begin
            nxt_st   = HOLD;
            nxt_hold = HOLD_Q;
          end else begin
            nxt_tmo = tmo_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (req) begin
            nxt_hold = HOLD_Q;
          end else if (hold_cnt == 16'd0) begin
            nxt_st  = CLOSING;
            nxt_tmo = 16'd0;
          end else begin
            nxt_hold = hold_cnt - 16'd1;
          end
        end
        CLOSING: begin
          if (tmo_cnt == TMO_LAST) begin
            nxt_st = FAULT;
          end else if (s_lclosed) begin
            nxt_st = IDLE;
          end else if (req) begin
            // Someone is at the bin while it closes: reverse.
            nxt_st  = OPENING;
            nxt_tmo = 16'd0;
          end else begin
            nxt_tmo = tmo_cnt + 16'd1;
          end
        end
        DENY: begin
          // Leaving on the count of 1 gives exactly ALARM_CYC alarm cycles.
          if (alarm_cnt <= 16'd1) begin
            nxt_st    = IDLE;
            nxt_alarm = 16'd0;
          end else begin
            nxt_alarm = alarm_cnt - 16'd1;
          end
        end
        FAULT: begin
          nxt_st = FAULT;
        end
        default: begin
          nxt_st = IDLE;
        end
      endcase
    end
  end

  // State register with Moore outputs decoded from the next state, so the
  // outputs flip on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      tmo_cnt       <= 16'd0;
      hold_cnt      <= 16'd0;
      alarm_cnt     <= 16'd0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      alarm_q       <= 1'b0;
      full_lo_q     <= 1'b0;
      full_hi_q     <= 1'b0;
    end else begin
      st            <= nxt_st;
      tmo_cnt       <= nxt_tmo;
      hold_cnt      <= nxt_hold;
      alarm_cnt     <= nxt_alarm;
      motor_open_q  <= (nxt_st == OPENING);
      motor_close_q <= (nxt_st == CLOSING);
      alarm_q       <= (nxt_st == DENY) || (nxt_st == FAULT);
      full_lo_q     <= flo_sync[1];
      full_hi_q     <= fhi_sync[1];
    end
  end

  assign io.motor_open  = motor_open_q;
  assign io.motor_close = motor_close_q;
  assign io.alarm       = alarm_q;
  assign io.full_lo     = full_lo_q;
  assign io.full_hi     = full_hi_q;
  assign io.state       = st;

endmodule

// File: tb/tb_smartbing_lid_ctrl.sv
// tb/tb_smartbing_lid_ctrl.sv - scoreboard bench for smartbing_lid_ctrl
module tb_smartbing_lid_ctrl;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int TMO  = 30;
  localparam int ALM  = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  smartbing_lid_ctrl_if io ();

  smartbing_lid_ctrl #(
    .DEB_CYC    (DEB),
    .HOLD_CYC   (HOLD),
    .TIMEOUT_CYC(TMO),
    .ALARM_CYC  (ALM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  int mark  = 0;
  int seq   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // kind: 0 = no timing check, 1 = cycles since previous state change,
  // 2 = cycles since the stimulus mark.
  typedef struct {
    logic [2:0] st;
    logic       mo;
    logic       mc;
    logic       al;
    int         kind;
    int         dly;
    int         id;
  } exp_t;

  exp_t sbq[$];

  task automatic expect_st(input logic [2:0] st, input int kind, input int dly);
    exp_t e;
    e.st   = st;
    e.mo   = (st == 3'd1);
    e.mc   = (st == 3'd3);
    e.al   = (st == 3'd4) || (st == 3'd5);
    e.kind = kind;
    e.dly  = dly;
    e.id   = seq;
    seq++;
    sbq.push_back(e);
  endtask

  // Monitor: every observed state change pops one expectation.
  logic [2:0] prev_st  = 3'd0;
  int         last_chg = 0;
  exp_t       got;

  initial forever begin
    @(negedge clk);
    chk("overlap", {31'd0, io.motor_open & io.motor_close}, 32'd0);
    if (io.state !== prev_st) begin
      if (sbq.size() == 0) begin
        chk("unexpected_state", {29'd0, io.state}, {29'd0, prev_st});
      end else begin
        got = sbq.pop_front();
        chk($sformatf("tr%0d_state", got.id), {29'd0, io.state}, {29'd0, got.st});
        chk($sformatf("tr%0d_motor_open", got.id), {31'd0, io.motor_open}, {31'd0, got.mo});
        chk($sformatf("tr%0d_motor_close", got.id), {31'd0, io.motor_close}, {31'd0, got.mc});
        chk($sformatf("tr%0d_alarm", got.id), {31'd0, io.alarm}, {31'd0, got.al});
        if (got.kind == 1)
          chk($sformatf("tr%0d_delay", got.id), cyc - last_chg, got.dly);
        else if (got.kind == 2)
          chk($sformatf("tr%0d_latency", got.id), cyc - mark, got.dly);
      end
      prev_st  = io.state;
      last_chg = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d want finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_st(input string tag, input logic [2:0] st, input int budget);
    int i = 0;
    while (io.state !== st && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, {29'd0, io.state}, {29'd0, st});
  endtask

  task automatic open_pulse(input int highs);
    expect_st(3'd1, 2, DEB + 3);
    mark = cyc;
    io.sense_user = 1'b1;
    step(highs);
    io.sense_user = 1'b0;
    wait_st("w_open", 3'd1, 20);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, {29'd0, io.state}, 32'd0);
    chk({tag, "_mo"}, {31'd0, io.motor_open}, 32'd0);
    chk({tag, "_mc"}, {31'd0, io.motor_close}, 32'd0);
    chk({tag, "_alarm"}, {31'd0, io.alarm}, 32'd0);
    chk({tag, "_full_lo"}, {31'd0, io.full_lo}, 32'd0);
    chk({tag, "_full_hi"}, {31'd0, io.full_hi}, 32'd0);
  endtask

  initial begin
    io.sense_user = 1'b0;
    io.lim_open   = 1'b0;
    io.lim_closed = 1'b0;
    io.fill_lo    = 1'b1;
    io.fill_hi    = 1'b1;

    // Reset holds every output low even with fill sensors active.
    step(4);
    check_reset_outputs("reset");
    io.fill_lo = 1'b0;
    io.fill_hi = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(4);

    // Glitch: one short of the debounce length.
    io.sense_user = 1'b1;
    step(DEB - 1);
    io.sense_user = 1'b0;
    step(12);
    chk("glitch_state", {29'd0, io.state}, 32'd0);
    chk("glitch_mo", {31'd0, io.motor_open}, 32'd0);
    chk("glitch_mc", {31'd0, io.motor_close}, 32'd0);

    // Normal cycle.
    open_pulse(10);
    step(8);
    expect_st(3'd2, 2, 3);
    mark = cyc;
    io.lim_open = 1'b1;
    wait_st("w_hold1", 3'd2, 10);
    step(1);
    io.lim_open = 1'b0;
    expect_st(3'd3, 1, HOLD + 1);
    wait_st("w_close1", 3'd3, HOLD + 10);

    // Anti-pinch re-open while closing.
    step(2);
    open_pulse(DEB + 1);
    step(5);
    expect_st(3'd2, 2, 3);
    mark = cyc;
    io.lim_open = 1'b1;
    wait_st("w_hold2", 3'd2, 10);
    step(1);
    io.lim_open = 1'b0;
    expect_st(3'd3, 1, HOLD + 1);
    wait_st("w_close2", 3'd3, HOLD + 10);
    step(3);
    expect_st(3'd0, 2, 3);
    mark = cyc;
    io.lim_closed = 1'b1;
    wait_st("w_idle1", 3'd0, 10);
    step(2);
    io.lim_closed = 1'b0;
    step(4);

    // Fill indicators: three-cycle latency.
    io.fill_lo = 1'b1;
    step(2);
    chk("full_lo_early", {31'd0, io.full_lo}, 32'd0);
    step(1);
    chk("full_lo_lat", {31'd0, io.full_lo}, 32'd1);
    io.fill_hi = 1'b1;
    step(2);
    chk("full_hi_early", {31'd0, io.full_hi}, 32'd0);
    step(1);
    chk("full_hi_lat", {31'd0, io.full_hi}, 32'd1);
    step(1);

    // Full bin: request denied with an ALARM_CYC alarm.
    expect_st(3'd4, 2, DEB + 3);
    mark = cyc;
    io.sense_user = 1'b1;
    wait_st("w_deny", 3'd4, 20);
    io.sense_user = 1'b0;
    expect_st(3'd0, 1, ALM);
    wait_st("w_deny_idle", 3'd0, ALM + 10);
    io.fill_hi = 1'b0;
    io.fill_lo = 1'b0;
    step(4);
    chk("full_hi_clear", {31'd0, io.full_hi}, 32'd0);
    chk("full_lo_clear", {31'd0, io.full_lo}, 32'd0);

    // Exactly DEB_CYC highs opens; then stall into FAULT.
    open_pulse(DEB);
    expect_st(3'd5, 1, TMO);
    wait_st("w_fault_tmo", 3'd5, TMO + 10);
    io.sense_user = 1'b1;
    step(10);
    io.sense_user = 1'b0;
    step(20);
    chk("fault_keep_state", {29'd0, io.state}, 32'd5);
    chk("fault_keep_alarm", {31'd0, io.alarm}, 32'd1);
    chk("fault_keep_mo", {31'd0, io.motor_open}, 32'd0);
    chk("fault_keep_mc", {31'd0, io.motor_close}, 32'd0);
    expect_st(3'd0, 0, 0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    check_reset_outputs("fault_rst");

    // Both limits during HOLD.
    open_pulse(DEB);
    step(3);
    expect_st(3'd2, 2, 3);
    mark = cyc;
    io.lim_open = 1'b1;
    wait_st("w_hold3", 3'd2, 10);
    step(2);
    expect_st(3'd5, 2, 3);
    mark = cyc;
    io.lim_closed = 1'b1;
    wait_st("w_fault_lim", 3'd5, 10);
    io.lim_open   = 1'b0;
    io.lim_closed = 1'b0;
    expect_st(3'd0, 0, 0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(4);

    // Asynchronous reset in the middle of OPENING.
    io.fill_lo = 1'b1;
    step(4);
    open_pulse(DEB);
    step(4);
    chk("pre_rst_mo", {31'd0, io.motor_open}, 32'd1);
    chk("pre_rst_full_lo", {31'd0, io.full_lo}, 32'd1);
    expect_st(3'd0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    io.fill_lo = 1'b0;
    step(5);

    chk("sb_left", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/smartbing_lid_ctrl.md
# smartbing_lid_ctrl

Lid-sequencing controller for the SmartBing waste bin. It synchronises and debounces the user-presence sensor, drives the lid motor open/close, and stops at the open/closed limit switches. It also latches fill-level indicators, and raises the alarm on a full-bin request or a motor fault. It sits between the raw `ui_in` sensor pins and the `uo_out` actuator/indicator pins of the top level.

## Interface
Parameters:
- `DEB_CYC`, 4 — consecutive synchronised-high cycles required to accept a user request (1..255).
- `HOLD_CYC`, 1000 — cycles the lid stays open after the last valid request (1..65535).
- `TIMEOUT_CYC`, 2000 — maximum cycles in OPENING or CLOSING before fault (1..65535).
- `ALARM_CYC`, 500 — length of the full-bin alarm pulse (1..65535).

Ports:
- `clk`  in  1  system clock; the block uses only this clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sense_user`  in  1  presence sensor, asynchronous to `clk`.
- `lim_open`  in  1  lid fully-open limit switch, asynchronous.
- `lim_closed`  in  1  lid fully-closed limit switch, asynchronous.
- `fill_lo`  in  1  fill level ≥ half, asynchronous.
- `fill_hi`  in  1  fill level full, asynchronous.
- `motor_open`  out  1  drive lid toward open.
- `motor_close`  out  1  drive lid toward closed.
- `full_lo`  out  1  half-full indicator.
- `full_hi`  out  1  full indicator.
- `alarm`  out  1  alarm buzzer/LED.
- `state`  out  3  current FSM state code, for debug.

## Operation
- All five inputs pass through 2-FF synchronisers. `full_lo` and `full_hi` are the synchronised `fill_lo` and `fill_hi`, registered once more.
- Debounce: an 8-bit counter increments while synchronised `sense_user` is 1, clears on 0, and saturates at `DEB_CYC`.
- `req` is high during each cycle in which the counter equals `DEB_CYC`, so a held sensor gives a continuous `req`.
- FSM states and codes: IDLE=0, OPENING=1, HOLD=2, CLOSING=3, DENY=4, FAULT=5.
- IDLE: if `req` and `full_hi`, go to DENY and load the alarm counter with `ALARM_CYC`. Else if `req`, go to OPENING and clear the timeout counter.
- OPENING: `motor_open`=1. `lim_open` goes to HOLD and loads the hold counter with `HOLD_CYC`. Timeout counter = `TIMEOUT_CYC`-1 goes to FAULT.
- HOLD: the hold counter decrements each cycle, and `req` reloads it to `HOLD_CYC`. When the counter reaches 0, go to CLOSING and clear the timeout counter.
- CLOSING: `motor_close`=1.
  - `lim_closed` goes to IDLE.
  - `req` goes to OPENING (anti-pinch re-open) and clears the timeout counter.
  - Timeout goes to FAULT.
- DENY: `alarm`=1 and the alarm counter decrements. At 0, go to IDLE. `req` during DENY is ignored; the lid stays closed.
- FAULT: both motors off, `alarm`=1. FAULT is terminal until `rst_n`.
- Per-cycle priority, highest first:
  1. `lim_open` and `lim_closed` both synchronised high in any non-FAULT state → FAULT.
  2. Timeout.
  3. Limit switch.
  4. `req`.
- `full_hi` rising while in OPENING or HOLD does not abort; the current cycle completes normally.
- `motor_open` and `motor_close` are never 1 in the same cycle.
- Reset mid-motion immediately deasserts both motors (asynchronous) and returns to IDLE.

## Timing
- Reset values: state=IDLE (000), `motor_open`=0, `motor_close`=0, `alarm`=0, `full_lo`=0, `full_hi`=0; all counters 0.
- Outputs are registered (Moore). `motor_open`, `motor_close`, `alarm` and `state` change in the same cycle as the state register.
- Request latency: `sense_user` rising at cycle 0 → `req` at cycle 2+`DEB_CYC` → `motor_open`=1 at cycle 3+`DEB_CYC`.
- Limit switch rising at cycle 0 → motor off at cycle 3 (2 sync + 1 FSM).
- Fill indicator latency: 3 cycles.
- Timeout: the FAULT transition happens `TIMEOUT_CYC` cycles after entering OPENING or CLOSING, if no limit switch is seen.
- HOLD lasts `HOLD_CYC`+1 cycles after the last `req`.
- A `sense_user` pulse shorter than `DEB_CYC`+... cycles, i.e. with fewer than `DEB_CYC` consecutive synchronised highs, never produces `req`.

## Test plan
- Normal cycle (`DEB_CYC`=4): hold `sense_user` for 10 cycles → `motor_open` at cycle 7. `lim_open` → HOLD. After `HOLD_CYC`, `motor_close` → `lim_closed` → IDLE (`state`=0).
- Glitch rejection: `sense_user` high for 3 cycles, then low → `state` stays 0 and both motors stay 0.
- Full bin: `fill_hi`=1, then `sense_user` held → `state`=4 and `alarm`=1 for exactly `ALARM_CYC` cycles. `motor_open` never asserts; then `state`=0.
- Re-open: `req` during CLOSING → next state OPENING, `motor_close`=0 and `motor_open`=1 with no overlap cycle.
- Stall: OPENING with `lim_open` held at 0 → FAULT after `TIMEOUT_CYC` cycles, `alarm`=1, motors 0. State persists despite further `req`, and clears only when `rst_n` is pulsed low.
- Fault and reset: both limits asserted during HOLD → FAULT within 3 cycles. Separately, assert `rst_n` low mid-OPENING → `motor_open`=0 immediately (same cycle) and all outputs return to their reset values.
